// File: rtl/rv32i_cpu.sv
// Single-cycle RV32I execution core: one instruction word per clock, 32x32 register file,
// 64-word data memory, registered writeback on Result. Define CPU_MUL_EN to add MUL.
module rv32i_cpu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instr,
  output logic [31:0] Result
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] F7_BASE  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;
  localparam logic [6:0] F7_MUL   = 7'b0000001;

  logic [31:0] regs [32];
  logic [31:0] mem  [64];

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_sel;
  logic [5:0]  mem_idx;
  logic [1:0]  ea_lo;
  logic        unused_ea;

  logic        exec_ok;
  logic        is_store;
  logic [31:0] wb;

  assign opcode  = Instr[6:0];
  assign rd      = Instr[11:7];
  assign funct3  = Instr[14:12];
  assign rs1     = Instr[19:15];
  assign rs2     = Instr[24:20];
  assign funct7  = Instr[31:25];
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
  assign imm_i   = {{20{Instr[31]}}, Instr[31:20]};
  assign imm_s   = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
  assign imm_sel = (opcode == OP_STORE) ? imm_s : imm_i;

  // Only address bits [7:2] select a word; the sum wraps naturally at 8 bits.
  assign {mem_idx, ea_lo} = rs1_val[7:0] + imm_sel[7:0];
  assign unused_ea        = ^ea_lo;

  // Shared R/I datapath; alt selects SUB (R only) or arithmetic right shift.
  function automatic logic [31:0] alu(input logic [2:0] op3, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op3)
      3'b000:  r = alt ? (a - b) : (a + b);
      3'b001:  r = a << b[4:0];
      3'b010:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b011:  r = (a < b) ? 32'd1 : 32'd0;
      3'b100:  r = a ^ b;
      3'b101:  r = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'b110:  r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  always_comb begin
    exec_ok  = 1'b0;
    is_store = 1'b0;
    wb       = 32'd0;
    case (opcode)
      OP_R: begin
        if (funct7 == F7_BASE ||
            (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          exec_ok = 1'b1;
          wb      = alu(funct3, funct7[5], rs1_val, rs2_val);
        end
`ifdef CPU_MUL_EN
        else if (funct7 == F7_MUL && funct3 == 3'b000) begin
          exec_ok = 1'b1;
          wb      = rs1_val * rs2_val;
        end
`endif
      end
      OP_I: begin
        if ((funct3 != 3'b001 && funct3 != 3'b101) ||
            (funct3 == 3'b001 && funct7 == F7_BASE) ||
            (funct3 == 3'b101 && (funct7 == F7_BASE || funct7 == F7_ALT))) begin
          exec_ok = 1'b1;
          wb      = alu(funct3, (funct3 == 3'b101) && Instr[30], rs1_val, imm_i);
        end
      end
      OP_LUI: begin
        exec_ok = 1'b1;
        wb      = {Instr[31:12], 12'd0};
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          exec_ok = 1'b1;
          wb      = mem[mem_idx];
        end
      end
      OP_STORE: begin
        if (funct3 == 3'b010) begin
          exec_ok  = 1'b1;
          is_store = 1'b1;
          wb       = rs2_val;
        end
      end
      default: ;
    endcase
  end

  // Writeback / architectural state update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Result <= 32'd0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      for (int j = 0; j < 64; j++) mem[j] <= 32'd0;
    end else if (exec_ok) begin
      Result <= wb;
      if (is_store)
        mem[mem_idx] <= rs2_val;
      else if (rd != 5'd0)
        regs[rd] <= wb;
    end
  end

endmodule

// File: tb/tb_rv32i_cpu.sv
// Self-checking bench for rv32i_cpu: directed program plus randomized instruction mix
// compared against an architectural reference model.
module tb_rv32i_cpu;

  logic        clk;
  logic        rst;
  logic [31:0] Instr;
  logic [31:0] Result;

  rv32i_cpu dut (
    .clk    (clk),
    .rst    (rst),
    .Instr  (Instr),
    .Result (Result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  logic [31:0] rf [32];
  logic [31:0] dm [64];
  logic [31:0] m_result;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2,
                                        input logic [4:0] s1, input logic [2:0] f3,
                                        input logic [4:0] d);
    return {f7, s2, s1, f3, d, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] s1,
                                        input logic [2:0] f3, input logic [4:0] d,
                                        input logic [6:0] op);
    return {imm, s1, f3, d, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] s2,
                                        input logic [4:0] s1);
    return {imm[11:5], s2, s1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] d);
    return {imm, d, 7'b0110111};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    for (int i = 0; i < 64; i++) dm[i] = 32'd0;
    m_result = 32'd0;
  endtask

  // Architectural effect of one instruction, by mnemonic.
  task automatic model_step(input logic [31:0] ins);
    logic [31:0] a, b, immi, imms, v, addr;
    logic [4:0]  d, sh;
    logic [2:0]  f3;
    logic [6:0]  f7;
    bit ok, store;
    a = rf[ins[19:15]];
    b = rf[ins[24:20]];
    d = ins[11:7];
    f3 = ins[14:12];
    f7 = ins[31:25];
    sh = ins[24:20];
    immi = {{20{ins[31]}}, ins[31:20]};
    imms = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ok = 1'b1;
    store = 1'b0;
    v = 32'd0;
    case (ins[6:0])
      7'b0110011: begin
        if (f7 == 7'h00 && f3 == 3'd0) v = a + b;
        else if (f7 == 7'h20 && f3 == 3'd0) v = a - b;
        else if (f7 == 7'h00 && f3 == 3'd1) v = a << b[4:0];
        else if (f7 == 7'h00 && f3 == 3'd2) v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        else if (f7 == 7'h00 && f3 == 3'd3) v = (a < b) ? 32'd1 : 32'd0;
        else if (f7 == 7'h00 && f3 == 3'd4) v = a ^ b;
        else if (f7 == 7'h00 && f3 == 3'd5) v = a >> b[4:0];
        else if (f7 == 7'h20 && f3 == 3'd5) v = 32'($signed(a) >>> b[4:0]);
        else if (f7 == 7'h00 && f3 == 3'd6) v = a | b;
        else if (f7 == 7'h00 && f3 == 3'd7) v = a & b;
`ifdef CPU_MUL_EN
        else if (f7 == 7'h01 && f3 == 3'd0) v = 32'(longint'(a) * longint'(b));
`endif
        else ok = 1'b0;
      end
      7'b0010011: begin
        case (f3)
          3'd0: v = a + immi;
          3'd2: v = ($signed(a) < $signed(immi)) ? 32'd1 : 32'd0;
          3'd3: v = (a < immi) ? 32'd1 : 32'd0;
          3'd4: v = a ^ immi;
          3'd6: v = a | immi;
          3'd7: v = a & immi;
          3'd1: if (f7 == 7'h00) v = a << sh; else ok = 1'b0;
          default: begin
            if (f7 == 7'h00) v = a >> sh;
            else if (f7 == 7'h20) v = 32'($signed(a) >>> sh);
            else ok = 1'b0;
          end
        endcase
      end
      7'b0110111: v = {ins[31:12], 12'd0};
      7'b0000011: begin
        addr = a + immi;
        if (f3 == 3'd2) v = dm[addr[7:2]]; else ok = 1'b0;
      end
      7'b0100011: begin
        if (f3 == 3'd2) begin
          store = 1'b1;
          v = b;
        end else ok = 1'b0;
      end
      default: ok = 1'b0;
    endcase
    if (ok) begin
      m_result = v;
      if (store) begin
        addr = a + imms;
        dm[addr[7:2]] = b;
      end else if (d != 5'd0) begin
        rf[d] = v;
      end
    end
  endtask

  task automatic finish_cycle(input logic [31:0] ins, input string tag);
    @(posedge clk);
    model_step(ins);
    #1;
    check_eq(tag, Result, m_result);
  endtask

  task automatic exec(input logic [31:0] ins, input string tag);
    @(negedge clk);
    Instr = ins;
    finish_cycle(ins, tag);
  endtask

  task automatic exec_exp(input logic [31:0] ins, input logic [31:0] exp, input string tag);
    exec(ins, tag);
    check_eq({tag, "_lit"}, Result, exp);
  endtask

  function automatic logic [31:0] gen_rand();
    logic [4:0] d, s1, s2;
    logic [2:0] f3;
    logic [6:0] f7;
    int k;
    d  = 5'($urandom_range(0, 7));
    s1 = 5'($urandom_range(0, 7));
    s2 = 5'($urandom_range(0, 7));
    f3 = 3'($urandom_range(0, 7));
    k  = $urandom_range(0, 9);
    case (k)
      0, 1: begin
        case ($urandom_range(0, 3))
          0: f7 = 7'h20;
          1: f7 = 7'h01;
          default: f7 = 7'h00;
        endcase
        return enc_r(f7, s2, s1, f3, d);
      end
      2, 3: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
          return {f7, 5'($urandom), s1, f3, d, 7'b0010011};
        end
        return enc_i(12'($urandom), s1, f3, d, 7'b0010011);
      end
      4: return enc_u(20'($urandom), d);
      5, 6: return enc_i(12'($urandom), s1, ($urandom_range(0, 7) == 0) ? f3 : 3'd2, d, 7'b0000011);
      7, 8: return enc_s(12'($urandom), s2, s1);
      default: return $urandom;
    endcase
  endfunction

  task automatic readback_all(input string tag);
    for (int i = 1; i < 32; i++) exec(enc_i(12'd0, 5'(i), 3'd0, 5'd0, 7'b0010011), {tag, "_reg"});
    for (int i = 0; i < 64; i++) exec(enc_i(12'(4 * i), 5'd0, 3'd2, 5'd0, 7'b0000011), {tag, "_mem"});
  endtask

  initial begin
    rst = 1'b0;
    Instr = $urandom;
    model_reset();
    #1 rst = 1'b1;
    #1 check_eq("reset_async", Result, 32'd0);
    repeat (3) begin
      @(negedge clk);
      Instr = $urandom;
      @(posedge clk);
      #1 check_eq("reset_hold", Result, 32'd0);
    end

    @(negedge clk);
    Instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
    rst = 1'b0;
    finish_cycle(Instr, "first_add");
    check_eq("first_add_lit", Result, 32'd0);

    exec_exp(enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'b0010011), 32'h00000005, "addi_pos");
    exec_exp(enc_i(12'hFFD, 5'd0, 3'd0, 5'd2, 7'b0010011), 32'hFFFFFFFD, "addi_neg");
    exec_exp(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'h00000002, "add");
    exec_exp(enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd4), 32'hFFFFFFF8, "sub");
    exec_exp(enc_r(7'h00, 5'd1, 5'd2, 3'd2, 5'd5), 32'h00000001, "slt");
    exec_exp(enc_r(7'h00, 5'd1, 5'd2, 3'd3, 5'd5), 32'h00000000, "sltu");
    exec_exp(enc_u(20'h80000, 5'd7), 32'h80000000, "lui");
    exec_exp(enc_i(12'h404, 5'd7, 3'd5, 5'd8, 7'b0010011), 32'hF8000000, "srai");
    exec_exp(enc_i(12'h004, 5'd7, 3'd5, 5'd8, 7'b0010011), 32'h08000000, "srli");
    exec_exp(enc_s(12'd8, 5'd1, 5'd0), 32'h00000005, "sw");
    exec_exp(enc_i(12'd8, 5'd0, 3'd2, 5'd6, 7'b0000011), 32'h00000005, "lw");
    exec_exp(enc_i(12'd264, 5'd0, 3'd2, 5'd6, 7'b0000011), 32'h00000005, "lw_wrap");
    exec_exp(enc_i(12'd12, 5'd0, 3'd2, 5'd6, 7'b0000011), 32'h00000000, "lw_empty");
    exec_exp(enc_i(12'd7, 5'd0, 3'd0, 5'd0, 7'b0010011), 32'h00000007, "addi_x0");
    exec_exp(enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd9), 32'h00000000, "x0_reads_zero");
    exec_exp(32'h00000000, 32'h00000000, "nop_zero");
    exec_exp(enc_i(12'h123, 5'd0, 3'd0, 5'd11, 7'b0010011), 32'h00000123, "addi_marker");
    exec_exp(32'h00000000, 32'h00000123, "nop_hold");
`ifdef CPU_MUL_EN
    exec_exp(enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd10), 32'hFFFFFFF1, "mul");
`else
    exec_exp(enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd10), 32'h00000123, "mul_disabled");
`endif

    for (int n = 0; n < 400; n++) exec(gen_rand(), "random");
    readback_all("post_random");

    exec_exp(enc_i(12'h055, 5'd0, 3'd0, 5'd1, 7'b0010011), 32'h00000055, "pre_reset");
    @(negedge clk);
    Instr = enc_i(12'd9, 5'd0, 3'd0, 5'd2, 7'b0010011);
    #2 rst = 1'b1;
    #1 check_eq("midstream_reset_async", Result, 32'd0);
    model_reset();
    @(posedge clk);
    #1 check_eq("reset_edge_no_write", Result, 32'd0);
    @(negedge clk);
    Instr = enc_i(12'd0, 5'd2, 3'd0, 5'd0, 7'b0010011);
    rst = 1'b0;
    finish_cycle(Instr, "x2_after_reset");
    check_eq("x2_after_reset_lit", Result, 32'd0);
    readback_all("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no_finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rv32i_cpu.md
# rv32i_cpu

Single-clock RV32I integer execution core driven directly by an instruction word per cycle. It has no instruction fetch, PC or branches. It executes one instruction per clock against a 32×32 register file and a 64-word data memory, and exposes each instruction's writeback value on `Result`. It is the top-level DUT of the CPU verification environment: the bus-functional model drives `Instr` and `rst` and monitors `Result`.

## Interface
- No parameters.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `Instr` in 32: RV32I instruction word; sampled at every rising edge.
- `Result` out 32: registered writeback value of the most recently executed instruction.

## Operation
- Decode is standard RV32I: opcode `[6:0]`, rd `[11:7]`, funct3 `[14:12]`, rs1 `[19:15]`, rs2 `[24:20]`, funct7 `[31:25]`.
- Supported R-type (opcode 0110011):
  - ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - funct7 0100000 selects SUB or SRA; 0000000 selects the rest.
- Supported I-type ALU (opcode 0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - 12-bit immediate, sign-extended.
  - Shift amount is `Instr[24:20]`; `Instr[30]` selects SRAI.
- LUI (0110111): rd = `{Instr[31:12], 12'b0}`.
- LW (0000011, funct3 010): rd = mem[(rs1+imm)[7:2]].
- SW (0100011, funct3 010): mem[(rs1+imm_s)[7:2]] = rs2, with imm_s = `{Instr[31:25], Instr[11:7]}` sign-extended.
- Data memory:
  - 64 × 32-bit words; address bits `[1:0]` are ignored and bits above `[7:2]` wrap.
  - Read is combinational within the cycle; write happens at the rising edge.
- Arithmetic and shifts:
  - All arithmetic is 32-bit modulo 2^32; overflow is ignored.
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned; both produce 1 or 0.
  - Shifts use the low 5 bits of the shift operand; SRA/SRAI sign-fill.
- `Result` update rules:
  - Every supported instruction loads `Result` with its computed value, even when rd = x0.
  - For SW, `Result` loads the store data (rs2 value).
- Register file:
  - x0 always reads 0; writes to x0 are discarded.
  - Writes to x1..x31 occur at the rising edge.
- Unsupported encodings (any other opcode, funct3 or funct7 combination, including all-zero): no register or memory change, and `Result` holds its previous value.
- Read-after-write: an instruction reads register and memory state as left by the previous edge, so back-to-back dependent instructions need no stalls.

## Timing
- Reset (async assert):
  - `Result` = 0; all registers x1..x31 = 0; all memory words = 0.
  - Effective immediately, independent of `clk`.
- While `rst` is high, `Instr` is ignored.
- After `rst` deasserts, the first rising edge executes `Instr`.
- Latency: `Instr` presented before edge N has its effect visible in `Result`, the register file and memory immediately after edge N. Throughput is one instruction per cycle.
- Reset asserted mid-stream discards any in-flight effect: the edge coinciding with reset performs no write.

## Configuration
- `CPU_MUL_EN` defined:
  - Adds MUL: R-type, funct7 0000001, funct3 000.
  - rd = low 32 bits of rs1×rs2; product is identical for signed and unsigned operands.
- `CPU_MUL_EN` undefined: that encoding is unsupported, i.e. treated as a NOP with `Result` held.

## Test plan
- Reset: assert `rst` with random `Instr` -> `Result` = 0x00000000. After release, ADD x3,x1,x2 -> `Result` = 0.
- Arithmetic: ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SUB x4,x2,x1 -> `Result` 0x00000005, 0xFFFFFFFD, 0x00000002, 0xFFFFFFF8 on successive cycles.
- Compare and shift:
  - SLT x5,x2,x1 -> 1; SLTU x5,x2,x1 -> 0.
  - LUI x7,0x80000 -> 0x80000000; SRAI x8,x7,4 -> 0xF8000000; SRLI x8,x7,4 -> 0x08000000.
- Memory: with x1 = 5, SW x1,8(x0) -> `Result` 5. Then LW x6,8(x0) -> 5; LW x6,264(x0) (address wraps to word 2) -> 5; LW x6,12(x0) -> 0.
- x0 and NOP:
  - ADDI x0,x0,7 -> `Result` 7; then ADD x9,x0,x0 -> 0.
  - `Instr` = 0x00000000 -> `Result` holds 0 and no state changes.
- MUL: with x1 = 5 and x2 = -3, MUL x10,x1,x2 -> 0xFFFFFFF1 with `CPU_MUL_EN`; with the macro undefined, `Result` holds its previous value.
